tx_frame_arbiter: RTL and testbench

// Multi-channel successor to the single-FIFO Aurora TX controller: round-robin arbitrates NCH FWFT FIFOs onto one

---
 rtl/tx_frame_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/tx_frame_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_pkg.sv
// Shared framing constants, field widths and FSM state encoding for the
// multi-channel LocalLink TX frame arbiter.
package tx_frame_pkg;

    localparam logic [7:0]  HDR_MARK       = 8'hA5;
    localparam logic [7:0]  TRL_MARK       = 8'hE0;
    localparam logic [31:0] KEEPALIVE_WORD = 32'h5A00_0000;

    localparam int CHAN_W = 8;
    localparam int SEQ_W  = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TRL,
        ST_KEEP
    } state_e;

    function automatic logic [31:0] frame_word(input logic [7:0]  mark,
                                               input logic [7:0]  chan,
                                               input logic [15:0] field);
        return {mark, chan, field};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted request at or after the
// pointer, wrapping at NCH, returned as one-hot grant plus index.
module rr_arbiter #(
    parameter  int NCH = 4,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] grant_o,
    output logic [IW-1:0]  idx_o,
    output logic           valid_o
);

    always_comb begin
        int c;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int i = 0; i < NCH; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NCH) c = c - NCH;
            if (!valid_o && req_i[c]) begin
                valid_o    = 1'b1;
                idx_o      = IW'(c);
                grant_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin framer: drains NCH FWFT FIFOs onto one LocalLink TX stream as
// header/data/trailer bursts, with keepalive words on an idle link.
module tx_frame_arbiter
    import tx_frame_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NCH          = 4,
    parameter int MAX_BURST    = 256,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 link_active,
    input  logic                 enable_i,
    output logic [WIDTH-1:0]     tx_d,
    output logic                 tx_src_rdy_n,
    input  logic                 tx_dst_rdy_n,
    input  logic [NCH*WIDTH-1:0] fifo_data_i,
    input  logic [NCH-1:0]       fifo_empty_i,
    output logic [NCH-1:0]       fifo_read_o,
    output logic [31:0]          frame_cnt_o,
    output logic                 abort_o
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0]    IDLE_LAST = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    state_e             state_q;
    logic [IW-1:0]      sel_q;
    logic [NCH-1:0]     sel_oh_q;
    logic [IW-1:0]      rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [TW-1:0]      idle_q;
    logic [WIDTH-1:0]   txd_q;
    logic               src_rdy_n_q;
    logic [31:0]        frame_cnt_q;
    logic               abort_q;

    logic [NCH-1:0]     arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic               xfer, load_ok, word_ok, pop;
    logic [WIDTH-1:0]   sel_word;
    logic [7:0]         chan8;
    logic [IW-1:0]      rr_next;

    function automatic logic [WIDTH-1:0] mk_word(input logic [31:0] w);
        logic [WIDTH-1:0] r;
        r       = '0;
        r[31:0] = w;
        return r;
    endfunction

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req_i   (~fifo_empty_i),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // The output register may take a new word when empty or when its word leaves now.
    assign xfer     = !src_rdy_n_q && !tx_dst_rdy_n;
    assign load_ok  = src_rdy_n_q || !tx_dst_rdy_n;
    assign word_ok  = !fifo_empty_i[sel_q] && (cnt_q < BURST_MAX);
    assign pop      = (state_q == ST_DATA) && link_active && load_ok && word_ok;
    assign sel_word = fifo_data_i[sel_q*WIDTH +: WIDTH];
    assign chan8    = CHAN_W'(sel_q);
    assign rr_next  = (sel_q == IW'(NCH - 1)) ? '0 : sel_q + 1'b1;

    // Pop is combinational so the FWFT word is captured on the same edge that pops it.
    assign fifo_read_o  = pop ? sel_oh_q : '0;
    assign tx_d         = txd_q;
    assign tx_src_rdy_n = src_rdy_n_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign abort_o      = abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            sel_oh_q    <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            seq_q       <= '0;
            idle_q      <= '0;
            txd_q       <= '0;
            src_rdy_n_q <= 1'b1;
            frame_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (state_q != ST_IDLE && !link_active) begin
                // Link loss drops whatever is in flight; an open frame still consumes its seq slot.
                state_q     <= ST_IDLE;
                src_rdy_n_q <= 1'b1;
                idle_q      <= '0;
                if (state_q != ST_KEEP) begin
                    abort_q <= 1'b1;
                    seq_q   <= seq_q + 1'b1;
                    rr_q    <= rr_next;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (link_active && enable_i && arb_valid) begin
                            sel_q    <= arb_idx;
                            sel_oh_q <= arb_grant;
                            idle_q   <= '0;
                            state_q  <= ST_HDR;
                        end else if (IDLE_TIMEOUT > 0 && link_active && idle_q == IDLE_LAST) begin
                            idle_q  <= '0;
                            state_q <= ST_KEEP;
                        end else if (src_rdy_n_q && idle_q != IDLE_LAST) begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                    ST_HDR: begin
                        if (load_ok) begin
                            txd_q       <= mk_word(frame_word(HDR_MARK, chan8, seq_q));
                            src_rdy_n_q <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (load_ok) begin
                            src_rdy_n_q <= 1'b0;
                            if (word_ok) begin
                                txd_q <= sel_word;
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                txd_q   <= mk_word(frame_word(TRL_MARK, chan8, cnt_q));
                                state_q <= ST_TRL;
                            end
                        end
                    end
                    ST_TRL: begin
                        if (xfer) begin
                            src_rdy_n_q <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                            seq_q       <= seq_q + 1'b1;
                            rr_q        <= rr_next;
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_KEEP: begin
                        if (src_rdy_n_q) begin
                            txd_q       <= mk_word(KEEPALIVE_WORD);
                            src_rdy_n_q <= 1'b0;
                        end else if (xfer) begin
                            src_rdy_n_q <= 1'b1;
                            idle_q      <= '0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: FWFT FIFO model, stream monitor and
// one task per scenario with hand-computed expected words.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

    localparam int W       = 32;
    localparam int NCH     = 4;
    localparam logic [31:0] KA = 32'h5A00_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             link_active = 1'b1;
    logic             enable_i = 1'b1;
    logic             tx_dst_rdy_n = 1'b0;
    logic [W-1:0]     tx_d;
    logic             tx_src_rdy_n;
    logic [NCH*W-1:0] fifo_data_i;
    logic [NCH-1:0]   fifo_empty_i;
    logic [NCH-1:0]   fifo_read_o;
    logic [31:0]      frame_cnt_o;
    logic             abort_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tx_frame_arbiter #(
        .WIDTH(W), .NCH(NCH), .MAX_BURST(4), .IDLE_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link_active  (link_active),
        .enable_i     (enable_i),
        .tx_d         (tx_d),
        .tx_src_rdy_n (tx_src_rdy_n),
        .tx_dst_rdy_n (tx_dst_rdy_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_read_o  (fifo_read_o),
        .frame_cnt_o  (frame_cnt_o),
        .abort_o      (abort_o)
    );

    // FWFT FIFO model: tasks append at tail, pops applied just after the edge.
    logic [31:0]    fmem [NCH][64];
    int             head [NCH] = '{default: 0};
    int             tail [NCH] = '{default: 0};
    logic [NCH-1:0] pend = '0;

    always_comb begin
        fifo_empty_i = '0;
        fifo_data_i  = '0;
        for (int c = 0; c < NCH; c++) begin
            fifo_empty_i[c]       = (head[c] == tail[c]);
            fifo_data_i[c*W +: W] = fmem[c][head[c] % 64];
        end
    end

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NCH; c++)
            if (pend[c] && head[c] != tail[c]) head[c] <= head[c] + 1;
    end

    // Stream monitor, sampled on the falling edge.
    logic [31:0] obuf [1024];
    int          ocyc [1024];
    int          ocnt = 0, cyc = 0, aborts = 0;
    int          pops [NCH] = '{default: 0};
    int          onehot_err = 0, stall_pop_err = 0, stab_err = 0, stalls = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        stall_now;

    assign stall_now = rst_n && link_active && !tx_src_rdy_n && tx_dst_rdy_n;

    always @(negedge clk) begin
        cyc  <= cyc + 1;
        pend <= fifo_read_o;
        if (rst_n && !tx_src_rdy_n && !tx_dst_rdy_n && ocnt < 1024) begin
            obuf[ocnt] <= tx_d;
            ocyc[ocnt] <= cyc;
            ocnt       <= ocnt + 1;
        end
        for (int c = 0; c < NCH; c++) pops[c] <= pops[c] + int'(fifo_read_o[c]);
        if (abort_o) aborts <= aborts + 1;
        if ($countones(fifo_read_o) > 1) onehot_err <= onehot_err + 1;
        if (stall_now) stalls <= stalls + 1;
        if (stall_now && fifo_read_o != '0) stall_pop_err <= stall_pop_err + 1;
        if (prev_stall && rst_n && link_active && (tx_src_rdy_n || tx_d !== prev_d))
            stab_err <= stab_err + 1;
        prev_stall <= stall_now;
        prev_d     <= tx_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        link_active  = 1'b1;
        enable_i     = 1'b1;
        tx_dst_rdy_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic push(input int c, input logic [31:0] w);
        fmem[c][tail[c] % 64] = w;
        tail[c] = tail[c] + 1;
    endtask

    task automatic wait_xfers(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (ocnt >= target) ok = 1'b1;
            else tick();
        end
        if (ocnt >= target) ok = 1'b1;
    endtask

    task automatic test_reset();
        int  b;
        bit  ok;
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) push(c, 32'h1100_0000 + c);
        tick(); tick(); tick();
        n_checks++; if (tx_src_rdy_n !== 1'b1) $display("FAIL reset_src_rdy got %b want 1", tx_src_rdy_n); else n_pass++;
        n_checks++; if (fifo_read_o !== 4'b0) $display("FAIL reset_read got %b want 0000", fifo_read_o); else n_pass++;
        n_checks++; if (frame_cnt_o !== 32'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt_o); else n_pass++;
        n_checks++; if (abort_o !== 1'b0) $display("FAIL reset_abort got %b want 0", abort_o); else n_pass++;
        n_checks++; if (tx_d !== 32'd0) $display("FAIL reset_tx_d got %h want 0", tx_d); else n_pass++;
        b = ocnt;
        rst_n = 1'b1;
        wait_xfers(b + 12, 100, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL reset_drain_timeout got %0d words want 12", ocnt - b); else n_pass++;
        n_checks++; if (frame_cnt_o !== 32'd4) $display("FAIL reset_drain_frames got %0d want 4", frame_cnt_o); else n_pass++;
        n_checks++; if (obuf[b] !== 32'hA500_0000) $display("FAIL reset_first_hdr got %h want A5000000", obuf[b]); else n_pass++;
        n_checks++; if (obuf[b+9] !== 32'hA503_0003) $display("FAIL reset_last_hdr got %h want A5030003", obuf[b+9]); else n_pass++;
        n_checks++; if (obuf[b+11] !== 32'hE003_0001) $display("FAIL reset_last_trl got %h want E0030001", obuf[b+11]); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [31:0] e [5];
        int  b, p;
        bit  ok;
        do_reset();
        for (int i = 0; i < 3; i++) push(2, 32'hD000_0000 + i);
        e = '{32'hA502_0000, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hE002_0003};
        b = ocnt;
        p = pops[2];
        rst_n = 1'b1;
        wait_xfers(b + 5, 50, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL single_timeout got %0d words want 5", ocnt - b); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obuf[b+i] !== e[i]) $display("FAIL single_word%0d got %h want %h", i, obuf[b+i], e[i]); else n_pass++;
        end
        n_checks++; if (frame_cnt_o !== 32'd1) $display("FAIL single_frame_cnt got %0d want 1", frame_cnt_o); else n_pass++;
        n_checks++; if (pops[2] - p !== 3) $display("FAIL single_pops got %0d want 3", pops[2] - p); else n_pass++;
    endtask

    task automatic test_max_burst();
        logic [31:0] e [19];
        int  b, p0, p1;
        bit  ok;
        do_reset();
        for (int i = 0; i < 10; i++) push(0, 32'hC000_0000 + i);
        push(1, 32'hC100_0000);
        e = '{32'hA500_0000, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hE000_0004,
              32'hA501_0001, 32'hC100_0000, 32'hE001_0001,
              32'hA500_0002, 32'hC000_0004, 32'hC000_0005, 32'hC000_0006, 32'hC000_0007, 32'hE000_0004,
              32'hA500_0003, 32'hC000_0008, 32'hC000_0009, 32'hE000_0002};
        b  = ocnt;
        p0 = pops[0];
        p1 = pops[1];
        rst_n = 1'b1;
        wait_xfers(b + 19, 200, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL burst_timeout got %0d words want 19", ocnt - b); else n_pass++;
        for (int i = 0; i < 19; i++) begin
            n_checks++;
            if (obuf[b+i] !== e[i]) $display("FAIL burst_word%0d got %h want %h", i, obuf[b+i], e[i]); else n_pass++;
        end
        n_checks++; if (frame_cnt_o !== 32'd4) $display("FAIL burst_frame_cnt got %0d want 4", frame_cnt_o); else n_pass++;
        n_checks++; if (pops[0] - p0 !== 10) $display("FAIL burst_pops_ch0 got %0d want 10", pops[0] - p0); else n_pass++;
        n_checks++; if (pops[1] - p1 !== 1) $display("FAIL burst_pops_ch1 got %0d want 1", pops[1] - p1); else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [31:0] e [6];
        int  b, p, s0, se0, sp0;
        bit  ok;
        do_reset();
        for (int i = 0; i < 4; i++) push(3, 32'hB300_0000 + i);
        e = '{32'hA503_0000, 32'hB300_0000, 32'hB300_0001, 32'hB300_0002, 32'hB300_0003, 32'hE003_0004};
        b   = ocnt;
        p   = pops[3];
        s0  = stalls;
        se0 = stab_err;
        sp0 = stall_pop_err;
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (ocnt >= b + 6) ok = 1'b1;
            else begin
                tx_dst_rdy_n = ~tx_dst_rdy_n;
                tick();
            end
        end
        tx_dst_rdy_n = 1'b0;
        tick();
        n_checks++; if (!ok) $display("FAIL bp_timeout got %0d words want 6", ocnt - b); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obuf[b+i] !== e[i]) $display("FAIL bp_word%0d got %h want %h", i, obuf[b+i], e[i]); else n_pass++;
        end
        n_checks++; if (stalls - s0 < 3) $display("FAIL bp_stall_seen got %0d want >=3", stalls - s0); else n_pass++;
        n_checks++; if (stab_err - se0 !== 0) $display("FAIL bp_stable got %0d changes want 0", stab_err - se0); else n_pass++;
        n_checks++; if (stall_pop_err - sp0 !== 0) $display("FAIL bp_stall_pop got %0d want 0", stall_pop_err - sp0); else n_pass++;
        n_checks++; if (pops[3] - p !== 4) $display("FAIL bp_pops got %0d want 4", pops[3] - p); else n_pass++;
        n_checks++; if (frame_cnt_o !== 32'd1) $display("FAIL bp_frame_cnt got %0d want 1", frame_cnt_o); else n_pass++;
    endtask

    task automatic test_link_drop();
        logic [31:0] e [6];
        int  b, b2, a0, p1;
        bit  ok;
        do_reset();
        for (int i = 0; i < 4; i++) push(1, 32'h6100_0000 + i);
        push(2, 32'h6200_0000);
        b  = ocnt;
        a0 = aborts;
        p1 = pops[1];
        rst_n = 1'b1;
        wait_xfers(b + 3, 50, ok);
        link_active  = 1'b0;
        tx_dst_rdy_n = 1'b1;
        n_checks++; if (!ok) $display("FAIL drop_timeout got %0d words want 3", ocnt - b); else n_pass++;
        n_checks++; if (obuf[b+2] !== 32'h6100_0001) $display("FAIL drop_pre_word got %h want 61000001", obuf[b+2]); else n_pass++;
        tick();
        n_checks++; if (abort_o !== 1'b1) $display("FAIL drop_abort got %b want 1", abort_o); else n_pass++;
        n_checks++; if (tx_src_rdy_n !== 1'b1) $display("FAIL drop_src_rdy got %b want 1", tx_src_rdy_n); else n_pass++;
        tick();
        n_checks++; if (abort_o !== 1'b0) $display("FAIL drop_abort_pulse got %b want 0", abort_o); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (aborts - a0 !== 1) $display("FAIL drop_abort_count got %0d want 1", aborts - a0); else n_pass++;
        n_checks++; if (frame_cnt_o !== 32'd0) $display("FAIL drop_frame_cnt got %0d want 0", frame_cnt_o); else n_pass++;
        e = '{32'hA502_0001, 32'h6200_0000, 32'hE002_0001, 32'hA501_0002, 32'h6100_0003, 32'hE001_0001};
        b2 = ocnt;
        link_active  = 1'b1;
        tx_dst_rdy_n = 1'b0;
        wait_xfers(b2 + 6, 100, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL relink_timeout got %0d words want 6", ocnt - b2); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obuf[b2+i] !== e[i]) $display("FAIL relink_word%0d got %h want %h", i, obuf[b2+i], e[i]); else n_pass++;
        end
        n_checks++; if (pops[1] - p1 !== 4) $display("FAIL relink_pops_ch1 got %0d want 4", pops[1] - p1); else n_pass++;
        n_checks++; if (frame_cnt_o !== 32'd2) $display("FAIL relink_frame_cnt got %0d want 2", frame_cnt_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        int  b, b2;
        bit  ok;
        do_reset();
        for (int i = 0; i < 3; i++) push(0, 32'h7000_0000 + i);
        b = ocnt;
        rst_n = 1'b1;
        wait_xfers(b + 2, 50, ok);
        n_checks++; if (!ok) $display("FAIL areset_timeout got %0d words want 2", ocnt - b); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_src_rdy_n !== 1'b1) $display("FAIL areset_src_rdy got %b want 1", tx_src_rdy_n); else n_pass++;
        n_checks++; if (tx_d !== 32'd0) $display("FAIL areset_tx_d got %h want 0", tx_d); else n_pass++;
        n_checks++; if (fifo_read_o !== 4'b0) $display("FAIL areset_read got %b want 0000", fifo_read_o); else n_pass++;
        tick();
        b2 = ocnt;
        rst_n = 1'b1;
        wait_xfers(b2 + 3, 50, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL areset_resume_timeout got %0d words want 3", ocnt - b2); else n_pass++;
        n_checks++; if (obuf[b2] !== 32'hA500_0000) $display("FAIL areset_hdr got %h want A5000000", obuf[b2]); else n_pass++;
        n_checks++; if (obuf[b2+1] !== 32'h7000_0002) $display("FAIL areset_data got %h want 70000002", obuf[b2+1]); else n_pass++;
        n_checks++; if (obuf[b2+2] !== 32'hE000_0001) $display("FAIL areset_trl got %h want E0000001", obuf[b2+2]); else n_pass++;
    endtask

    task automatic test_keepalive();
        int  b, b2, p, bad;
        bit  ok;
        do_reset();
        b = ocnt;
        rst_n = 1'b1;
        wait_xfers(b + 2, 80, ok);
        n_checks++; if (!ok) $display("FAIL ka_timeout got %0d words want 2", ocnt - b); else n_pass++;
        n_checks++; if (obuf[b] !== KA) $display("FAIL ka_word0 got %h want 5A000000", obuf[b]); else n_pass++;
        n_checks++; if (obuf[b+1] !== KA) $display("FAIL ka_word1 got %h want 5A000000", obuf[b+1]); else n_pass++;
        n_checks++; if (ocyc[b+1] - ocyc[b] !== 18) $display("FAIL ka_period got %0d want 18", ocyc[b+1] - ocyc[b]); else n_pass++;
        enable_i = 1'b0;
        push(0, 32'h8000_0000);
        push(0, 32'h8000_0001);
        b2 = ocnt;
        p  = pops[0];
        for (int i = 0; i < 60; i++) tick();
        bad = 0;
        for (int i = b2; i < ocnt; i++) if (obuf[i] !== KA) bad++;
        n_checks++; if (ocnt - b2 < 3) $display("FAIL ka_disabled_count got %0d want >=3", ocnt - b2); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL ka_disabled_nonka got %0d want 0", bad); else n_pass++;
        n_checks++; if (pops[0] - p !== 0) $display("FAIL ka_disabled_pops got %0d want 0", pops[0] - p); else n_pass++;
        n_checks++; if (frame_cnt_o !== 32'd0) $display("FAIL ka_disabled_frames got %0d want 0", frame_cnt_o); else n_pass++;
        n_checks++; if (onehot_err !== 0) $display("FAIL read_onehot got %0d violations want 0", onehot_err); else n_pass++;
        enable_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_max_burst();
        test_back_pressure();
        test_link_drop();
        test_async_reset();
        test_keepalive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
